// File: rtl/invaders_fleet_pkg.sv
// Shared game definitions: gameplay codes, fleet geometry and the fleet state type.
// Used by the fleet block and by the gameplay block.
package invaders_fleet_pkg;

   typedef enum logic [1:0] {
      PLAYING   = 2'b00,
      YOU_WIN   = 2'b01,
      GAME_OVER = 2'b10
   } gameplay_e;

   typedef enum logic [1:0] {
      MARCH   = 2'b00,
      DESCEND = 2'b01,
      HALT    = 2'b10
   } fleet_state_e;

   localparam int NUM_INVADERS = 20;
   localparam int LAST_LINE    = 13;

   function automatic logic [4:0] popcount20(input logic [19:0] mask);
      logic [4:0] total;
      total = 5'd0;
      for (int i = 0; i < 20; i++) begin
         total = total + {4'd0, mask[i]};
      end
      return total;
   endfunction

endpackage

// File: rtl/invaders_fleet_if.sv
// Game-side bus of the invader fleet: frame/hit inputs and the fleet position outputs.
interface invaders_fleet_if;
   logic        frame_tick;
   logic [1:0]  gameplay;
   logic        hit_valid;
   logic [4:0]  hit_index;
   logic [19:0] invaders_array;
   logic [3:0]  invaders_line;
   logic [3:0]  invaders_col;
   logic        direction;
   logic        hit_ack;

   modport master (
      output frame_tick, gameplay, hit_valid, hit_index,
      input  invaders_array, invaders_line, invaders_col, direction, hit_ack
   );

   modport slave (
      input  frame_tick, gameplay, hit_valid, hit_index,
      output invaders_array, invaders_line, invaders_col, direction, hit_ack
   );
endinterface

// File: rtl/invaders_fleet_step_timer.sv
// Frame counter that paces fleet steps; the period halves once the fleet is thin.
module fleet_step_timer #(
   parameter int STEP_FRAMES = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_tick,
   input  logic enable,
   input  logic half_speed,
   output logic step
);

   logic [5:0] cnt_r;
   logic [5:0] period_s;

   // Period selection and step strobe, combinational so the step lands on this edge
   always_comb begin
      period_s = 6'(STEP_FRAMES);
      step     = 1'b0;
      if (half_speed) begin
         period_s = 6'(STEP_FRAMES / 2);
      end else begin
         period_s = 6'(STEP_FRAMES);
      end
      if (enable && frame_tick && (cnt_r == period_s - 6'd1)) begin
         step = 1'b1;
      end else begin
         step = 1'b0;
      end
   end

   // Frame counter; a count stranded above a freshly halved period clears without stepping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= 6'd0;
      end else if (enable && frame_tick) begin
         if (cnt_r >= period_s - 6'd1) begin
            cnt_r <= 6'd0;
         end else begin
            cnt_r <= cnt_r + 6'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/invaders_fleet.sv
// Invader fleet: marches side to side, descends at the walls, tracks the alive mask and kills.
module invaders_fleet #(
   parameter int STEP_FRAMES = 30,
   parameter int MAX_COL     = 15,
   parameter int LAST_LINE   = invaders_fleet_pkg::LAST_LINE
) (
   input logic             clk_36MHz,
   input logic             reset,
   invaders_fleet_if.slave bus
);
   import invaders_fleet_pkg::*;

   localparam logic [3:0] MAX_COL_L   = 4'(MAX_COL);
   localparam logic [3:0] LAST_LINE_L = 4'(LAST_LINE);

   fleet_state_e state_r, state_s;
   logic [19:0]  array_r, array_s;
   logic [3:0]   line_r, line_s;
   logic [3:0]   col_r, col_s;
   logic         dir_r, dir_s;
   logic         hit_ack_r, hit_ack_s;
   logic [19:0]  hit_mask_s;
   logic         step_s;
   logic         enable_s;
   logic         half_speed_s;

   assign enable_s     = (state_r != HALT);
   assign half_speed_s = (popcount20(array_r) <= 5'd10);

   fleet_step_timer #(.STEP_FRAMES(STEP_FRAMES)) u_timer (
      .clk        (clk_36MHz),
      .reset      (reset),
      .frame_tick (bus.frame_tick),
      .enable     (enable_s),
      .half_speed (half_speed_s),
      .step       (step_s)
   );

   // Next-state: step movement, hit removal and the gameplay-driven halt
   always_comb begin
      state_s    = state_r;
      array_s    = array_r;
      line_s     = line_r;
      col_s      = col_r;
      dir_s      = dir_r;
      hit_ack_s  = 1'b0;
      hit_mask_s = 20'd0;
      if (bus.hit_index < 5'd20) begin
         hit_mask_s = 20'd1 << bus.hit_index;
      end else begin
         hit_mask_s = 20'd0;
      end
      if (state_r == HALT) begin
         state_s = HALT;
      end else begin
         if (step_s) begin
            case (state_r)
               MARCH: begin
                  if ((!dir_r && col_r == MAX_COL_L) || (dir_r && col_r == 4'd0)) begin
                     state_s = DESCEND;
                  end else if (!dir_r) begin
                     col_s = col_r + 4'd1;
                  end else begin
                     col_s = col_r - 4'd1;
                  end
               end
               DESCEND: begin
                  dir_s = ~dir_r;
                  if (line_r < LAST_LINE_L) begin
                     line_s = line_r + 4'd1;
                  end else begin
                     line_s = line_r;
                  end
                  if (line_s >= LAST_LINE_L) begin
                     state_s = HALT;
                  end else begin
                     state_s = MARCH;
                  end
               end
               default: state_s = HALT;
            endcase
         end else begin
            state_s = state_r;
         end
         // Hits on dead or out-of-range invaders see an empty mask and fall through
         if (bus.hit_valid && ((array_r & hit_mask_s) != 20'd0)) begin
            array_s   = array_r & ~hit_mask_s;
            hit_ack_s = 1'b1;
         end else begin
            hit_ack_s = 1'b0;
         end
         if (bus.gameplay != PLAYING) begin
            state_s = HALT;
         end else begin
            state_s = state_s;
         end
      end
   end

   // Fleet registers
   always_ff @(posedge clk_36MHz or posedge reset) begin
      if (reset) begin
         state_r   <= MARCH;
         array_r   <= 20'hFFFFF;
         line_r    <= 4'd0;
         col_r     <= 4'd0;
         dir_r     <= 1'b0;
         hit_ack_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         array_r   <= array_s;
         line_r    <= line_s;
         col_r     <= col_s;
         dir_r     <= dir_s;
         hit_ack_r <= hit_ack_s;
      end
   end

   assign bus.invaders_array = array_r;
   assign bus.invaders_line  = line_r;
   assign bus.invaders_col   = col_r;
   assign bus.direction      = dir_r;
   assign bus.hit_ack        = hit_ack_r;

endmodule

// File: tb/tb_invaders_fleet.sv
// Bench for invaders_fleet: behavioural fleet model checked every cycle plus pinned literals.
module tb_invaders_fleet;

   localparam int SF = 4;

   logic clk;
   logic reset;
   bit   chk_en;
   int   n_cmp;
   int   n_fail;

   // Model of the fleet, expressed as game rules rather than hardware states
   logic [19:0] m_arr;
   int          m_line;
   int          m_col;
   bit          m_dir;
   bit          m_ack;
   int          m_frames;
   bit          m_halt;
   bit          m_at_wall;

   invaders_fleet_if bus ();

   invaders_fleet #(.STEP_FRAMES(SF), .MAX_COL(15), .LAST_LINE(13)) dut (
      .clk_36MHz (clk),
      .reset     (reset),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_arr     = 20'hFFFFF;
      m_line    = 0;
      m_col     = 0;
      m_dir     = 1'b0;
      m_ack     = 1'b0;
      m_frames  = 0;
      m_halt    = 1'b0;
      m_at_wall = 1'b0;
   endtask

   task automatic model_edge();
      int period;
      bit stp;
      int idx;
      stp   = 1'b0;
      m_ack = 1'b0;
      if (!m_halt) begin
         period = ($countones(m_arr) > 10) ? SF : SF / 2;
         if (bus.frame_tick) begin
            if (m_frames == period - 1) begin
               stp      = 1'b1;
               m_frames = 0;
            end else if (m_frames >= period) begin
               m_frames = 0;
            end else begin
               m_frames++;
            end
         end
         if (stp) begin
            if (m_at_wall) begin
               if (m_line < 13) m_line++;
               m_dir     = ~m_dir;
               m_at_wall = 1'b0;
               if (m_line == 13) m_halt = 1'b1;
            end else if ((m_dir == 1'b0 && m_col == 15) || (m_dir == 1'b1 && m_col == 0)) begin
               m_at_wall = 1'b1;
            end else begin
               m_col = m_dir ? m_col - 1 : m_col + 1;
            end
         end
         idx = int'(bus.hit_index);
         if (bus.hit_valid && idx < 20) begin
            if (m_arr[idx]) begin
               m_arr[idx] = 1'b0;
               m_ack      = 1'b1;
            end
         end
         if (bus.gameplay != 2'b00) m_halt = 1'b1;
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         cmp("array", {12'd0, bus.invaders_array}, {12'd0, m_arr});
         cmp("line", {28'd0, bus.invaders_line}, 32'(m_line));
         cmp("col", {28'd0, bus.invaders_col}, 32'(m_col));
         cmp("direction", {31'd0, bus.direction}, {31'd0, m_dir});
         cmp("hit_ack", {31'd0, bus.hit_ack}, {31'd0, m_ack});
      end
   end

   task automatic cycle(input bit ft);
      bus.frame_tick = ft;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.hit_valid  = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1);
         cycle(1'b0);
      end
   endtask

   task automatic hit(input int idx, output bit ack);
      bus.hit_valid = 1'b1;
      bus.hit_index = 5'(idx);
      cycle(1'b0);
      ack = bus.hit_ack;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      cmp("rst_array", {12'd0, bus.invaders_array}, 32'h000FFFFF);
      cmp("rst_line", {28'd0, bus.invaders_line}, 32'd0);
      cmp("rst_col", {28'd0, bus.invaders_col}, 32'd0);
      cmp("rst_dir", {31'd0, bus.direction}, 32'd0);
      cmp("rst_ack", {31'd0, bus.hit_ack}, 32'd0);
      bus.gameplay = 2'b00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit ack;
      int acks;
      n_cmp          = 0;
      n_fail         = 0;
      chk_en         = 1'b0;
      reset          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.gameplay   = 2'b00;
      bus.hit_valid  = 1'b0;
      bus.hit_index  = 5'd0;
      model_reset();
      @(negedge clk);
      do_reset();
      chk_en = 1'b1;

      // First step after a full period, then march to the right wall and back
      ticks(4);
      cmp("lit_col_after_4", {28'd0, bus.invaders_col}, 32'd1);
      cmp("lit_line_after_4", {28'd0, bus.invaders_line}, 32'd0);
      cmp("lit_array_after_4", {12'd0, bus.invaders_array}, 32'h000FFFFF);
      ticks(4 * 14);
      cmp("lit_col_step15", {28'd0, bus.invaders_col}, 32'd15);
      ticks(4);
      cmp("lit_col_step16", {28'd0, bus.invaders_col}, 32'd15);
      cmp("lit_line_step16", {28'd0, bus.invaders_line}, 32'd0);
      ticks(4);
      cmp("lit_line_step17", {28'd0, bus.invaders_line}, 32'd1);
      cmp("lit_dir_step17", {31'd0, bus.direction}, 32'd1);
      cmp("lit_col_step17", {28'd0, bus.invaders_col}, 32'd15);
      ticks(4);
      cmp("lit_col_step18", {28'd0, bus.invaders_col}, 32'd14);

      // Kill, re-hit the corpse, and hit out of range
      acks = 0;
      hit(3, ack);  acks += int'(ack);
      hit(3, ack);  acks += int'(ack);
      hit(25, ack); acks += int'(ack);
      cmp("lit_hit_ack_count", 32'(acks), 32'd1);
      cmp("lit_array_hit3", {12'd0, bus.invaders_array}, 32'h000FFFF7);

      // Thin the fleet to ten: the next step arrives after two ticks
      for (int i = 0; i < 10; i++) begin
         if (i != 3) hit(i, ack);
      end
      cmp("lit_array_ten", {12'd0, bus.invaders_array}, 32'h000FFC00);
      ticks(1);
      cmp("lit_col_half_tick1", {28'd0, bus.invaders_col}, 32'd14);
      ticks(1);
      cmp("lit_col_half_tick2", {28'd0, bus.invaders_col}, 32'd13);

      // Descend all the way to the last line
      for (int i = 0; i < 3000 && !m_halt; i++) ticks(1);
      cmp("lit_halt_line", {28'd0, bus.invaders_line}, 32'd13);
      cmp("lit_halt_col", {28'd0, bus.invaders_col}, 32'd15);
      cmp("lit_halt_dir", {31'd0, bus.direction}, 32'd1);
      ticks(20);
      cmp("lit_halt_col_20", {28'd0, bus.invaders_col}, 32'd15);
      hit(19, ack);
      cmp("lit_halt_hit_ack", {31'd0, ack}, 32'd0);
      cmp("lit_halt_array", {12'd0, bus.invaders_array}, 32'h000FFC00);

      // Game over mid-march freezes the fleet; reset restores it
      do_reset();
      ticks(6);
      cmp("lit_go_col", {28'd0, bus.invaders_col}, 32'd1);
      bus.gameplay = 2'b10;
      cycle(1'b0);
      ticks(10);
      cmp("lit_go_frozen_col", {28'd0, bus.invaders_col}, 32'd1);
      cmp("lit_go_frozen_line", {28'd0, bus.invaders_line}, 32'd0);
      do_reset();
      ticks(3);
      cmp("lit_post_rst_col3", {28'd0, bus.invaders_col}, 32'd0);
      ticks(1);
      cmp("lit_post_rst_col4", {28'd0, bus.invaders_col}, 32'd1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
